// File: rtl/overlay_pkg.sv
// Shared definitions for the text-overlay frame sequencer: state encodings,
// layer bit positions and the shadow offset width.
package overlay_pkg;

  localparam int SHADOW_W = 4;

  localparam int LAYER_DEMO = 0;
  localparam int LAYER_TT08 = 1;
  localparam int LAYER_SDA  = 2;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_GROW      = 3'd1,
    ST_SHOW_DEMO = 3'd2,
    ST_SHOW_TT08 = 3'd3,
    ST_SHOW_SDA  = 3'd4,
    ST_BLINK     = 3'd5,
    ST_SHRINK    = 3'd6
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/overlay_frame_timer.sv
// Frame-tick counter with synchronous clear and a terminal-count pulse that
// auto-reloads, so one instance can time repeated periods within a state.
module overlay_frame_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_tick,
  input  logic         i_clear,
  input  logic [W-1:0] i_period,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_tc = i_tick && (r_cnt == (i_period - W'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      if (i_clear || o_tc) r_cnt <= '0;
      else                 r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/overlay_scheduler.sv
// Frame-rate sequencer for the text overlay: grow shadow, solo each text layer,
// blink all layers, shrink shadow, repeat. Everything advances only on frame_tick.
module overlay_scheduler
  import overlay_pkg::*;
#(
  parameter int DEFAULT_SHADOW = 4,
  parameter int MAX_SHADOW     = 7,
  parameter int STEP_FRAMES    = 4,
  parameter int DWELL_FRAMES   = 60,
  parameter int BLINK_FRAMES   = 15,
  parameter int BLINK_COUNT    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_frame_tick,
  input  logic                i_enable,
  output logic [2:0]          o_layer_en,
  output logic                o_shadow_en,
  output logic [SHADOW_W-1:0] o_shadow_off,
  output logic                o_busy,
  output logic [2:0]          o_state_dbg
);

  localparam int FCNT_W = $clog2(max3(STEP_FRAMES, DWELL_FRAMES, BLINK_FRAMES) + 1);
  localparam int BCNT_W = $clog2(2 * BLINK_COUNT);

  localparam logic [SHADOW_W-1:0] C_MAX = SHADOW_W'(MAX_SHADOW);
  localparam logic [SHADOW_W-1:0] C_DEF = SHADOW_W'(DEFAULT_SHADOW);
  localparam logic [BCNT_W-1:0]   C_LAST_HALF = BCNT_W'(2 * BLINK_COUNT - 1);

  localparam logic [2:0] M_ALL  = 3'b111;
  localparam logic [2:0] M_DEMO = 3'(1 << LAYER_DEMO);
  localparam logic [2:0] M_TT08 = 3'(1 << LAYER_TT08);
  localparam logic [2:0] M_SDA  = 3'(1 << LAYER_SDA);

  state_e              r_state, w_state_n;
  logic [2:0]          r_layer, w_layer_n;
  logic                r_shen,  w_shen_n;
  logic [SHADOW_W-1:0] r_off,   w_off_n;
  logic [BCNT_W-1:0]   r_bcnt,  w_bcnt_n;

  logic [FCNT_W-1:0]   w_period;
  logic                w_tc;
  logic                w_clear;
  logic [SHADOW_W-1:0] w_off_inc;
  logic [SHADOW_W-1:0] w_off_dec;

  // Offset saturates at both ends instead of wrapping.
  assign w_off_inc = (r_off >= C_MAX) ? C_MAX : r_off + SHADOW_W'(1);
  assign w_off_dec = (r_off == '0) ? '0 : r_off - SHADOW_W'(1);

  always_comb begin
    w_period = FCNT_W'(STEP_FRAMES);
    case (r_state)
      ST_SHOW_DEMO, ST_SHOW_TT08, ST_SHOW_SDA: w_period = FCNT_W'(DWELL_FRAMES);
      ST_BLINK:                                w_period = FCNT_W'(BLINK_FRAMES);
      default:                                 w_period = FCNT_W'(STEP_FRAMES);
    endcase
  end

  // Frame count restarts whenever the state changes and is held at zero in IDLE.
  assign w_clear = (w_state_n != r_state) || (r_state == ST_IDLE);

  overlay_frame_timer #(.W(FCNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_tick   (i_frame_tick),
    .i_clear  (w_clear),
    .i_period (w_period),
    .o_tc     (w_tc)
  );

  always_comb begin
    w_state_n = r_state;
    w_layer_n = r_layer;
    w_shen_n  = r_shen;
    w_off_n   = r_off;
    w_bcnt_n  = r_bcnt;
    if (!i_enable) begin
      w_state_n = ST_IDLE;
      w_layer_n = M_ALL;
      w_shen_n  = 1'b1;
      w_off_n   = C_DEF;
      w_bcnt_n  = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_n = ST_GROW;
          w_layer_n = M_ALL;
          w_shen_n  = 1'b1;
          w_off_n   = '0;
        end
        ST_GROW: if (w_tc) begin
          w_off_n = w_off_inc;
          if (w_off_inc == C_MAX) begin
            w_state_n = ST_SHOW_DEMO;
            w_layer_n = M_DEMO;
          end
        end
        ST_SHOW_DEMO: if (w_tc) begin
          w_state_n = ST_SHOW_TT08;
          w_layer_n = M_TT08;
        end
        ST_SHOW_TT08: if (w_tc) begin
          w_state_n = ST_SHOW_SDA;
          w_layer_n = M_SDA;
        end
        ST_SHOW_SDA: if (w_tc) begin
          w_state_n = ST_BLINK;
          w_layer_n = '0;
          w_shen_n  = 1'b0;
          w_bcnt_n  = '0;
        end
        // Entry already blanked the first half-period; the last half ends lit.
        ST_BLINK: if (w_tc) begin
          if (r_bcnt == C_LAST_HALF) begin
            w_state_n = ST_SHRINK;
            w_layer_n = M_ALL;
            w_shen_n  = 1'b1;
            w_bcnt_n  = '0;
          end else begin
            w_layer_n = ~r_layer;
            w_shen_n  = ~r_shen;
            w_bcnt_n  = r_bcnt + BCNT_W'(1);
          end
        end
        ST_SHRINK: if (w_tc) begin
          w_off_n = w_off_dec;
          if (w_off_dec == '0) w_state_n = ST_GROW;
        end
        default: begin
          w_state_n = ST_IDLE;
          w_layer_n = M_ALL;
          w_shen_n  = 1'b1;
          w_off_n   = C_DEF;
          w_bcnt_n  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_layer <= M_ALL;
      r_shen  <= 1'b1;
      r_off   <= C_DEF;
      r_bcnt  <= '0;
    end else if (i_frame_tick) begin
      r_state <= w_state_n;
      r_layer <= w_layer_n;
      r_shen  <= w_shen_n;
      r_off   <= w_off_n;
      r_bcnt  <= w_bcnt_n;
    end
  end

  assign o_layer_en   = r_layer;
  assign o_shadow_en  = r_shen;
  assign o_shadow_off = r_off;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_state_dbg  = r_state;

endmodule

// File: tb/tb_overlay_scheduler.sv
// Bench for overlay_scheduler: two instances (MAX_SHADOW=3 and 0) share stimulus and
// are checked tick by tick against an animation script built from the behavioural rules.
module tb_overlay_scheduler;

  localparam int P_STEP   = 2;
  localparam int P_DWELL  = 3;
  localparam int P_BLINK  = 2;
  localparam int P_BCOUNT = 2;
  localparam int P_MAX    = 3;
  localparam int P_DEF    = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       enable = 1'b0;

  logic [2:0] layer_a, state_a, layer_b, state_b;
  logic       shen_a, busy_a, shen_b, busy_b;
  logic [3:0] off_a, off_b;

  wire [11:0] obs_a = {state_a, layer_a, shen_a, off_a, busy_a};
  wire [11:0] obs_b = {state_b, layer_b, shen_b, off_b, busy_b};

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] exp_q[$];
  logic [11:0] exp0_q[$];
  logic [11:0] tmp_q[$];
  int          pos_a, pos_b;
  bit          run;
  logic [11:0] exp_a, exp_b;
  logic [11:0] idle_snap;

  always #5 clk = ~clk;

  overlay_scheduler #(
    .DEFAULT_SHADOW(P_DEF), .MAX_SHADOW(P_MAX), .STEP_FRAMES(P_STEP),
    .DWELL_FRAMES(P_DWELL), .BLINK_FRAMES(P_BLINK), .BLINK_COUNT(P_BCOUNT)
  ) dut_a (
    .clk(clk), .rst(rst), .i_frame_tick(frame_tick), .i_enable(enable),
    .o_layer_en(layer_a), .o_shadow_en(shen_a), .o_shadow_off(off_a),
    .o_busy(busy_a), .o_state_dbg(state_a)
  );

  overlay_scheduler #(
    .DEFAULT_SHADOW(P_DEF), .MAX_SHADOW(0), .STEP_FRAMES(P_STEP),
    .DWELL_FRAMES(P_DWELL), .BLINK_FRAMES(P_BLINK), .BLINK_COUNT(P_BCOUNT)
  ) dut_b (
    .clk(clk), .rst(rst), .i_frame_tick(frame_tick), .i_enable(enable),
    .o_layer_en(layer_b), .o_shadow_en(shen_b), .o_shadow_off(off_b),
    .o_busy(busy_b), .o_state_dbg(state_b)
  );

  function automatic logic [11:0] mk(input logic [2:0] st, input logic [2:0] ly,
                                     input logic sh, input logic [3:0] of);
    return {st, ly, sh, of, (st != 3'd0)};
  endfunction

  // One full loop as seen after each tick, starting at the GROW entry tick and
  // ending with the next GROW entry.
  task automatic build_script(input int mx);
    int         steps;
    logic [3:0] of;
    logic       sh;
    tmp_q.delete();
    steps = (mx == 0) ? 1 : mx;
    tmp_q.push_back(mk(3'd1, 3'b111, 1'b1, 4'd0));
    for (int k = 1; k <= steps; k++) begin
      repeat (P_STEP - 1) tmp_q.push_back(tmp_q[tmp_q.size() - 1]);
      of = 4'((k < mx) ? k : mx);
      if (k == steps) tmp_q.push_back(mk(3'd2, 3'b001, 1'b1, of));
      else            tmp_q.push_back(mk(3'd1, 3'b111, 1'b1, of));
    end
    for (int s = 0; s < 3; s++) begin
      repeat (P_DWELL - 1) tmp_q.push_back(tmp_q[tmp_q.size() - 1]);
      if (s < 2) tmp_q.push_back(mk(3'(3 + s), 3'(3'b010 << s), 1'b1, 4'(mx)));
      else       tmp_q.push_back(mk(3'd5, 3'b000, 1'b0, 4'(mx)));
    end
    sh = 1'b0;
    for (int h = 1; h <= 2 * P_BCOUNT; h++) begin
      repeat (P_BLINK - 1) tmp_q.push_back(tmp_q[tmp_q.size() - 1]);
      if (h == 2 * P_BCOUNT) tmp_q.push_back(mk(3'd6, 3'b111, 1'b1, 4'(mx)));
      else begin
        sh = ~sh;
        tmp_q.push_back(mk(3'd5, {3{sh}}, sh, 4'(mx)));
      end
    end
    for (int k = 1; k <= steps; k++) begin
      repeat (P_STEP - 1) tmp_q.push_back(tmp_q[tmp_q.size() - 1]);
      of = 4'((mx - k > 0) ? mx - k : 0);
      if (k == steps) tmp_q.push_back(mk(3'd1, 3'b111, 1'b1, 4'd0));
      else            tmp_q.push_back(mk(3'd6, 3'b111, 1'b1, of));
    end
  endtask

  task automatic model_step(input logic en);
    if (!en) run = 1'b0;
    else if (!run) begin
      run = 1'b1; pos_a = 0; pos_b = 0;
    end else begin
      pos_a = (pos_a + 1 == exp_q.size() - 1)  ? 0 : pos_a + 1;
      pos_b = (pos_b + 1 == exp0_q.size() - 1) ? 0 : pos_b + 1;
    end
    exp_a = run ? exp_q[pos_a]  : idle_snap;
    exp_b = run ? exp0_q[pos_b] : idle_snap;
  endtask

  task automatic pulse_tick(input logic en);
    @(negedge clk);
    enable = en;
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    model_step(en);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (obs_a !== idle_snap) begin
      n_errors++; $display("FAIL reset_a: got %h expected %h", obs_a, idle_snap);
    end
    n_checks++;
    if (obs_b !== idle_snap) begin
      n_errors++; $display("FAIL reset_b: got %h expected %h", obs_b, idle_snap);
    end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pulse_tick(1'b0);
      n_checks++;
      if (obs_a !== idle_snap) begin
        n_errors++; $display("FAIL idle_a tick %0d: got %h expected %h", i, obs_a, idle_snap);
      end
    end
  endtask

  task automatic test_sequence();
    for (int t = 1; t <= 2 * (exp_q.size() - 1) + 2; t++) begin
      pulse_tick(1'b1);
      n_checks++;
      if (obs_a !== exp_a) begin
        n_errors++; $display("FAIL seq_a tick %0d: got %h expected %h", t, obs_a, exp_a);
      end
      n_checks++;
      if (obs_b !== exp_b) begin
        n_errors++; $display("FAIL seq_b tick %0d: got %h expected %h", t, obs_b, exp_b);
      end
      if (t == 2) begin
        n_checks++;
        if (state_b !== 3'd1) begin
          n_errors++; $display("FAIL max0_grow tick 2: state %0d expected 1", state_b);
        end
      end
      if (t == 3) begin
        n_checks++;
        if (state_b !== 3'd2 || layer_b !== 3'b001 || off_b !== 4'd0) begin
          n_errors++; $display("FAIL max0_exit tick 3: state %0d layer %b off %0d expected 2 001 0",
                               state_b, layer_b, off_b);
        end
      end
      if (t == 7) begin
        n_checks++;
        if (state_a !== 3'd2 || layer_a !== 3'b001 || off_a !== 4'd3) begin
          n_errors++; $display("FAIL show_demo tick 7: state %0d layer %b off %0d expected 2 001 3",
                               state_a, layer_a, off_a);
        end
      end
      if (t == 16) begin
        n_checks++;
        if (state_a !== 3'd5 || layer_a !== 3'b000 || shen_a !== 1'b0) begin
          n_errors++; $display("FAIL blink_entry tick 16: state %0d layer %b shen %b expected 5 000 0",
                               state_a, layer_a, shen_a);
        end
      end
      if (t == 24) begin
        n_checks++;
        if (state_a !== 3'd6 || layer_a !== 3'b111 || off_a !== 4'd3) begin
          n_errors++; $display("FAIL shrink_entry tick 24: state %0d layer %b off %0d expected 6 111 3",
                               state_a, layer_a, off_a);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    int guard;
    guard = 0;
    while (!(run && exp_a[11:9] == 3'd3) && guard < 100) begin
      pulse_tick(1'b1);
      guard++;
      n_checks++;
      if (obs_a !== exp_a) begin
        n_errors++; $display("FAIL drop_pre_a: got %h expected %h", obs_a, exp_a);
      end
    end
    n_checks++;
    if (guard >= 100) begin
      n_errors++; $display("FAIL drop_reach: SHOW_TT08 not reached in %0d ticks, required < 100", guard);
    end
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs_a !== exp_a) begin
        n_errors++; $display("FAIL drop_hold cycle %0d: got %h expected %h", i, obs_a, exp_a);
      end
    end
    pulse_tick(1'b0);
    n_checks++;
    if (obs_a !== idle_snap) begin
      n_errors++; $display("FAIL drop_idle_a: got %h expected %h", obs_a, idle_snap);
    end
    n_checks++;
    if (obs_b !== idle_snap) begin
      n_errors++; $display("FAIL drop_idle_b: got %h expected %h", obs_b, idle_snap);
    end
  endtask

  task automatic test_async_reset();
    int guard;
    guard = 0;
    while (!(run && exp_a[11:9] == 3'd5 && exp_a[8:6] == 3'b000) && guard < 100) begin
      pulse_tick(1'b1);
      guard++;
    end
    n_checks++;
    if (obs_a !== exp_a || guard >= 100) begin
      n_errors++; $display("FAIL arst_pre: got %h expected %h after %0d ticks", obs_a, exp_a, guard);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_checks++;
    if (obs_a !== idle_snap) begin
      n_errors++; $display("FAIL arst_now_a: got %h expected %h", obs_a, idle_snap);
    end
    n_checks++;
    if (obs_b !== idle_snap) begin
      n_errors++; $display("FAIL arst_now_b: got %h expected %h", obs_b, idle_snap);
    end
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    exp_a = idle_snap;
    exp_b = idle_snap;
    pulse_tick(1'b1);
    n_checks++;
    if (obs_a !== exp_a) begin
      n_errors++; $display("FAIL arst_first_tick: got %h expected %h", obs_a, exp_a);
    end
  endtask

  task automatic test_random();
    int   gap;
    logic en;
    for (int i = 0; i < 300; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        n_checks++;
        if (obs_a !== exp_a) begin
          n_errors++; $display("FAIL rand_hold_a iter %0d: got %h expected %h", i, obs_a, exp_a);
        end
        enable = 1'($urandom_range(0, 1));
      end
      en = ($urandom_range(0, 19) != 0);
      pulse_tick(en);
      n_checks++;
      if (obs_a !== exp_a) begin
        n_errors++; $display("FAIL rand_a iter %0d en %b: got %h expected %h", i, en, obs_a, exp_a);
      end
      n_checks++;
      if (obs_b !== exp_b) begin
        n_errors++; $display("FAIL rand_b iter %0d en %b: got %h expected %h", i, en, obs_b, exp_b);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_snap = mk(3'd0, 3'b111, 1'b1, 4'(P_DEF));
    build_script(P_MAX);
    exp_q = tmp_q;
    build_script(0);
    exp0_q = tmp_q;
    run = 1'b0;
    exp_a = idle_snap;
    exp_b = idle_snap;

    test_reset();
    test_sequence();
    test_enable_drop();
    test_async_reset();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
